// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encoding and LCD geometry used by the PPU and its pixel sinks.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_t;

  localparam int LCD_W    = 160;
  localparam int LCD_H    = 144;
  localparam int FB_WORDS = LCD_W * LCD_H;

endpackage

// File: rtl/ppu_lcd_writer_if.sv
// Pixel stream in from the PPU and framebuffer write port out, as seen by the LCD writer.
interface ppu_lcd_writer_if #(
  parameter int ADDR_W = 16
);
  // PX_valid has no ready: the writer consumes every cycle where PX_valid=1.
  // FB_WR is a single-cycle write strobe; FB_ADDR/FB_DATA hold their last values while it is low.
  logic [1:0]        PX_IN;
  logic              PX_valid;
  logic [1:0]        PPU_MODE;
  logic              LCD_EN;
  logic              FB_WR;
  logic [ADDR_W-1:0] FB_ADDR;
  logic [1:0]        FB_DATA;

  modport master (
    output PX_IN, PX_valid, PPU_MODE, LCD_EN,
    input  FB_WR, FB_ADDR, FB_DATA
  );

  modport slave (
    input  PX_IN, PX_valid, PPU_MODE, LCD_EN,
    output FB_WR, FB_ADDR, FB_DATA
  );
endinterface

// File: rtl/ppu_lcd_writer.sv
// Writes the PPU pixel stream into a double-buffered framebuffer, swapping buffers at V-blank entry.
module ppu_lcd_writer #(
  parameter int LCD_W      = ppu_pkg::LCD_W,
  parameter int LCD_H      = ppu_pkg::LCD_H,
  parameter int BUF_STRIDE = ppu_pkg::FB_WORDS,
  parameter int ADDR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  ppu_lcd_writer_if.slave  bus,
  output logic             DISP_BUF,
  output logic             FRAME_DONE,
  output logic             LINE_ERR,
  output logic             OVF_ERR,
  output logic [0:0]       dbg_state
);
  import ppu_pkg::*;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [7:0]        X_LAST    = 8'(LCD_W - 1);
  localparam logic [7:0]        Y_END     = 8'(LCD_H);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LCD_W);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BUF_STRIDE);

  logic [0:0]        state;
  logic [7:0]        x, y;
  logic [ADDR_W-1:0] line_base;
  logic              wr_buf;
  ppu_mode_t         prev_mode;

  logic              fb_wr;
  logic [ADDR_W-1:0] fb_addr;
  logic [1:0]        fb_data;

  logic              hb_entry, vb_entry, in_frame, accept, short_line;
  logic [7:0]        x_n, y_n;
  logic [ADDR_W-1:0] lb_n, buf_off;

  // Pixel is counted before the short-line check, so a pixel arriving with
  // H-blank entry that completes the line suppresses the error.
  always_comb begin
    hb_entry   = (prev_mode == DRAW) && (bus.PPU_MODE == H_BLANK);
    vb_entry   = (prev_mode != V_BLANK) && (bus.PPU_MODE == V_BLANK);
    in_frame   = (y < Y_END);
    accept     = (state == ACTIVE) && bus.LCD_EN && bus.PX_valid && in_frame;
    buf_off    = wr_buf ? STRIDE : '0;
    x_n        = x;
    y_n        = y;
    lb_n       = line_base;
    short_line = 1'b0;
    if (accept) begin
      if (x == X_LAST) begin
        x_n  = '0;
        y_n  = y + 8'd1;
        lb_n = line_base + LINE_STEP;
      end else begin
        x_n = x + 8'd1;
      end
    end
    if (hb_entry && (x_n != 8'd0)) begin
      short_line = 1'b1;
      x_n        = '0;
      y_n        = y_n + 8'd1;
      lb_n       = lb_n + LINE_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      wr_buf     <= 1'b0;
      prev_mode  <= H_BLANK;
      fb_wr      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      DISP_BUF   <= 1'b1;
      FRAME_DONE <= 1'b0;
      LINE_ERR   <= 1'b0;
      OVF_ERR    <= 1'b0;
    end else begin
      prev_mode  <= ppu_mode_t'(bus.PPU_MODE);
      fb_wr      <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (!bus.LCD_EN) begin
        state     <= IDLE;
        x         <= '0;
        y         <= '0;
        line_base <= '0;
      end else if (state == IDLE) begin
        state     <= ACTIVE;
        x         <= '0;
        y         <= '0;
        line_base <= '0;
      end else begin
        if (accept) begin
          fb_wr   <= 1'b1;
          fb_data <= bus.PX_IN;
          fb_addr <= buf_off + line_base + ADDR_W'(x);
        end
        if (bus.PX_valid && !in_frame) OVF_ERR <= 1'b1;
        if (short_line) LINE_ERR <= 1'b1;
        // The pixel above still lands in the old buffer; the swap takes effect afterwards.
        if (vb_entry) begin
          wr_buf     <= ~wr_buf;
          DISP_BUF   <= wr_buf;
          FRAME_DONE <= 1'b1;
          x          <= '0;
          y          <= '0;
          line_base  <= '0;
        end else begin
          x         <= x_n;
          y         <= y_n;
          line_base <= lb_n;
        end
      end
    end
  end

  assign bus.FB_WR   = fb_wr;
  assign bus.FB_ADDR = fb_addr;
  assign bus.FB_DATA = fb_data;
  assign dbg_state   = state;

endmodule

// File: tb/tb_ppu_lcd_writer.sv
// Directed bench for ppu_lcd_writer: scoreboard of expected framebuffer writes plus status checks.
module tb_ppu_lcd_writer;
  import ppu_pkg::*;

  localparam int STRIDE = 23040;

  logic clk;
  logic rst;
  logic disp_buf, frame_done, line_err, ovf_err;
  logic [0:0] dbg_state;

  ppu_lcd_writer_if #(.ADDR_W(16)) bus();

  ppu_lcd_writer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .DISP_BUF   (disp_buf),
    .FRAME_DONE (frame_done),
    .LINE_ERR   (line_err),
    .OVF_ERR    (ovf_err),
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: {cycle, addr, data}
  logic [49:0] exp_q[$];
  logic [49:0] mon_e;
  int n_vec = 0;
  int n_err = 0;
  int fd_count = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.FB_WR) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write (cycle %0d)",
                 bus.FB_ADDR, bus.FB_DATA, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_cycle", cyc, mon_e[49:18]);
        check("wr_addr", bus.FB_ADDR, mon_e[17:2]);
        check("wr_data", bus.FB_DATA, mon_e[1:0]);
      end
    end
    if (frame_done) fd_count++;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic px(input logic [1:0] d, input int addr, input bit expect_wr);
    bus.PX_valid = 1'b1;
    bus.PX_IN    = d;
    if (expect_wr) exp_q.push_back({32'(cyc + 1), 16'(addr), d});
    tick();
  endtask

  task automatic full_line(input int base, input int y);
    for (int x = 0; x < 160; x++) px(2'((x + y) % 4), base + x, 1'b1);
    bus.PX_valid = 1'b0;
    bus.PPU_MODE = H_BLANK;
    tick();
    bus.PPU_MODE = DRAW;
  endtask

  int fd_before;

  initial begin
    rst          = 1'b1;
    bus.PX_IN    = '0;
    bus.PX_valid = 1'b0;
    bus.PPU_MODE = H_BLANK;
    bus.LCD_EN   = 1'b0;
    repeat (3) tick();
    check("rst_fb_wr", bus.FB_WR, 0);
    check("rst_fb_addr", bus.FB_ADDR, 0);
    check("rst_fb_data", bus.FB_DATA, 0);
    check("rst_disp_buf", disp_buf, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_err", line_err, 0);
    check("rst_ovf_err", ovf_err, 0);
    check("rst_state", dbg_state, 0);

    rst          = 1'b0;
    bus.LCD_EN   = 1'b1;
    bus.PPU_MODE = DRAW;
    tick();
    check("enable_state", dbg_state, 1);

    // frame 0: 144 full lines into buffer 0, addresses 0..23039
    for (int y = 0; y < 144; y++) full_line(y * 160, y);
    check("f0_line_err", line_err, 0);
    bus.PPU_MODE = V_BLANK;
    tick();
    check("f0_frame_done", frame_done, 1);
    check("f0_disp_buf", disp_buf, 0);
    tick();
    check("f0_frame_done_pulse", frame_done, 0);
    check("f0_ovf_err", ovf_err, 0);

    // frame 1: short line 0, then 143 full lines, then 5 overflow pixels
    bus.PPU_MODE = DRAW;
    for (int x = 0; x < 100; x++) px(2'(x % 4), STRIDE + x, 1'b1);
    bus.PX_valid = 1'b0;
    bus.PPU_MODE = H_BLANK;
    tick();
    bus.PPU_MODE = DRAW;
    check("short_line_err", line_err, 1);
    for (int y = 1; y < 144; y++) full_line(STRIDE + y * 160, y);
    check("pre_ovf_err", ovf_err, 0);
    for (int i = 0; i < 5; i++) px(2'(i), 0, 1'b0);
    bus.PX_valid = 1'b0;
    check("ovf_no_write", bus.FB_WR, 0);
    check("ovf_err", ovf_err, 1);
    bus.PPU_MODE = V_BLANK;
    tick();
    check("f1_frame_done", frame_done, 1);
    check("f1_disp_buf", disp_buf, 1);
    bus.PPU_MODE = DRAW;
    tick();

    // LCD disabled mid-line at x=50: no writes, no swap, no frame pulse
    for (int x = 0; x < 50; x++) px(2'(x % 4), x, 1'b1);
    fd_before  = fd_count;
    bus.LCD_EN = 1'b0;
    for (int i = 0; i < 5; i++) px(2'd3, 0, 1'b0);
    bus.PX_valid = 1'b0;
    bus.PPU_MODE = V_BLANK;
    tick();
    tick();
    check("dis_state", dbg_state, 0);
    check("dis_no_frame_done", fd_count, fd_before);
    check("dis_disp_buf", disp_buf, 1);

    // re-enable: restart at buffer 0 position 0; last pixel coincides with V-blank entry
    bus.PPU_MODE = DRAW;
    bus.LCD_EN   = 1'b1;
    tick();
    for (int x = 0; x < 10; x++) begin
      if (x == 9) bus.PPU_MODE = V_BLANK;
      px(2'((x + 1) % 4), x, 1'b1);
    end
    bus.PX_valid = 1'b0;
    check("vb_px_frame_done", frame_done, 1);
    check("vb_px_disp_buf", disp_buf, 0);
    bus.PPU_MODE = DRAW;
    tick();
    check("vb_px_pulse", frame_done, 0);
    for (int x = 0; x < 3; x++) px(2'(3 - x), STRIDE + x, 1'b1);

    // reset mid-frame with a pixel presented
    rst          = 1'b1;
    bus.PX_valid = 1'b1;
    bus.PX_IN    = 2'd3;
    tick();
    check("midrst_fb_wr", bus.FB_WR, 0);
    check("midrst_disp_buf", disp_buf, 1);
    check("midrst_line_err", line_err, 0);
    check("midrst_ovf_err", ovf_err, 0);
    check("midrst_state", dbg_state, 0);
    rst          = 1'b0;
    bus.PX_valid = 1'b0;
    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_lcd_writer.md
Name: ppu_lcd_writer

Overview:
- Downstream sink of the PPU pixel stream: consumes the 2-bit shade index (PX_OUT/PX_valid) and the PPU mode.
- Tracks the x/y raster position and writes each pixel into a double-buffered 160x144 framebuffer RAM.
- Swaps buffers at V-blank entry so the video scan-out side always reads a complete frame.
- Sits between the PPU and the framebuffer RAM / VGA scan-out logic.

Parameters:
- LCD_W, 160, visible pixels per line
- LCD_H, 144, visible lines per frame
- BUF_STRIDE, 23040, word offset of buffer 1 from buffer 0 (LCD_W*LCD_H)
- ADDR_W, 16, framebuffer address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- PX_IN  in  2  shade index from PPU (PX_OUT)
- PX_valid  in  1  PX_IN valid this cycle
- PPU_MODE  in  2  PPU mode: 0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
- LCD_EN  in  1  LCDC[7]
- FB_WR  out  1  framebuffer write strobe
- FB_ADDR  out  ADDR_W  framebuffer word address
- FB_DATA  out  2  pixel written
- DISP_BUF  out  1  buffer the scan-out side reads (the buffer not being written)
- FRAME_DONE  out  1  one-cycle pulse on frame completion
- LINE_ERR  out  1  sticky: line ended with a wrong pixel count
- OVF_ERR  out  1  sticky: pixel received past the last frame position

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - FB_WR=0, FB_ADDR=0, FB_DATA=0, DISP_BUF=1, FRAME_DONE=0, LINE_ERR=0, OVF_ERR=0.
  - Internal state: x=0, y=0, line_base=0, wr_buf=0, state=IDLE, prev_mode=0.
- prev_mode registers PPU_MODE every cycle.
  - hb_entry = (prev_mode==3 && PPU_MODE==0).
  - vb_entry = (prev_mode!=1 && PPU_MODE==1).
- States:
  - IDLE: LCD_EN=0. No writes, counters held at 0. On LCD_EN=1, go to ACTIVE with x=y=0 and line_base=0; the PPU begins at line 0.
  - ACTIVE:
    - Pixel accept: PX_valid=1 and y<LCD_H.
    - Next cycle: FB_WR=1, FB_DATA=PX_IN, FB_ADDR=wr_buf*BUF_STRIDE+line_base+x. Latency is exactly 1 cycle.
    - x increments; at x==LCD_W-1 it wraps to 0, y increments, and line_base += LCD_W. No multiplier is used.
    - PX_valid=1 with y>=LCD_H: pixel dropped, FB_WR=0, OVF_ERR set.
    - hb_entry with x!=0 (short line): x forced to 0, y++, line_base += LCD_W, LINE_ERR set.
    - hb_entry with x==0: no action; the normal wrap already occurred.
    - vb_entry: wr_buf toggles, DISP_BUF takes the old wr_buf, FRAME_DONE pulses 1 cycle, and x=y=line_base=0.
  - LCD_EN falling in any state: go to IDLE next cycle.
    - A write already in the output register still completes.
    - No FRAME_DONE pulse and no buffer swap.
- Simultaneous events:
  - PX_valid together with vb_entry: the pixel is written to the old buffer at its current position, then counters reset.
  - PX_valid together with hb_entry: the pixel is counted first, then the short-line check uses the updated x.
- FB_WR is deasserted every cycle without an accepted pixel. FB_ADDR and FB_DATA hold their last values.
- Sticky errors clear only on rst.
- Reset mid-frame: all state returns to reset values next cycle. The partial frame is abandoned and DISP_BUF returns to 1.
- Address width: worst case is 2*23040-1=46079, which fits in 16 bits.

Decomposition:
- Shared package ppu_pkg:
  - ppu_mode_t enum (H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3), used by the PPU and this block.
  - Constants LCD_W, LCD_H, FB_WORDS.
- Single module, no sub-module. The raster counter (x, y, line_base) is small enough to stay inline.

Test Plan:
- Reset then LCD_EN=1, 160 consecutive PX_valid with PX_IN=x%4 -> FB_WR for 160 cycles, FB_ADDR 0..159, each one cycle after input. x wraps to 0, y=1, next address 160.
- Full frame (144x160 pixels), then PPU_MODE 3->0->1 -> FRAME_DONE single pulse, DISP_BUF=0. Next frame's first pixel writes FB_ADDR=23040.
- Line of 100 pixels, then PPU_MODE 3->0 -> LINE_ERR=1; next pixel at FB_ADDR=160 (line 1, x=0).
- 144 full lines, then 5 more PX_valid before V-blank -> no FB_WR for the extra pixels, OVF_ERR=1; V-blank still swaps buffers.
- LCD_EN dropped mid-line at x=50 -> no further writes, no FRAME_DONE. Re-enable -> first pixel at FB_ADDR=wr_buf*23040+0.
- rst asserted mid-frame on a cycle with PX_valid=1 -> next cycle FB_WR=0, DISP_BUF=1, errors 0, state IDLE.
